// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: direct-mapped I-cache sequencer; 1-cycle hits, byte-serial refill on miss.
// Optional build macro ICACHE_FETCH_STATS_EN adds hit_cnt/miss_cnt statistics outputs.
module icache_fetch_ctrl #(
    parameter int INST_BYTES  = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        fetch_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    output logic [31:0] cache_addr,
    output logic        cache_wr,
    output logic [31:0] cache_data,
    input  logic        cache_hit,
    input  logic [31:0] cache_result,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
`ifdef ICACHE_FETCH_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    input  logic [7:0]  mem_din
);

    localparam logic [2:0] LAST  = 3'(INST_BYTES - 1);
    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  req_idx_q, req_idx_d;
    logic [2:0]  rsp_idx_q, rsp_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        cap_q, cap_d;
    logic [7:0]  stall_q, stall_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        cache_wr_q, cache_wr_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic        fetch_err_q, fetch_err_d;
    logic        accept;

    assign accept      = (state_q == IDLE) && fetch_valid && !flush;
    assign fetch_ready = (state_q == IDLE);
    assign cache_addr  = (state_q == IDLE) ? fetch_pc : pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst_out    = inst_out_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_err   = fetch_err_q;
    assign cache_wr    = cache_wr_q;
    assign cache_data  = cache_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Next-state logic: hit/miss dispatch, pipelined byte requests and captures, flush abort
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_idx_d    = req_idx_q;
        rsp_idx_d    = rsp_idx_q;
        asm_d        = asm_q;
        cap_d        = 1'b0;
        stall_d      = stall_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = 1'b0;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        cache_wr_d   = 1'b0;
        cache_data_d = cache_data_q;
        fetch_err_d  = fetch_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept && cache_hit) begin
                    inst_valid_d = 1'b1;
                    inst_out_d   = cache_result;
                    inst_pc_d    = fetch_pc;
                end else if (accept) begin
                    pc_d       = fetch_pc;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc;
                    req_idx_d  = 3'd0;
                    rsp_idx_d  = 3'd0;
                    asm_d      = 32'd0;
                    stall_d    = 8'd0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_req_q && mem_gnt) begin
                    req_idx_d  = req_idx_q + 3'd1;
                    mem_addr_d = pc_q + 32'(req_idx_q) + 32'd1;
                    cap_d      = 1'b1;
                    mem_req_d  = (req_idx_q != LAST);
                end
                // a grant wait longer than LIMIT cycles flags the error; the counter saturates
                if (mem_req_q && !mem_gnt) begin
                    fetch_err_d = fetch_err_q | (stall_q == LIMIT);
                    stall_d     = (stall_q == LIMIT) ? stall_q : stall_q + 8'd1;
                end else begin
                    stall_d = 8'd0;
                end
                // the byte returned for last cycle's grant lands little-endian in the buffer
                if (cap_q) begin
                    asm_d[{rsp_idx_q[1:0], 3'b000} +: 8] = mem_din;
                    rsp_idx_d = rsp_idx_q + 3'd1;
                    if (rsp_idx_q == LAST) begin
                        state_d      = WRITE;
                        cache_wr_d   = 1'b1;
                        cache_data_d = asm_d;
                        inst_valid_d = 1'b1;
                        inst_out_d   = asm_d;
                        inst_pc_d    = pc_q;
                    end
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a redirect discards everything in flight, including a byte already granted
        if (flush) begin
            state_d      = IDLE;
            mem_req_d    = 1'b0;
            cap_d        = 1'b0;
            stall_d      = 8'd0;
            inst_valid_d = 1'b0;
            inst_out_d   = inst_out_q;
            inst_pc_d    = inst_pc_q;
            cache_wr_d   = 1'b0;
            cache_data_d = cache_data_q;
        end
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            req_idx_q    <= 3'd0;
            rsp_idx_q    <= 3'd0;
            asm_q        <= 32'd0;
            cap_q        <= 1'b0;
            stall_q      <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= 32'd0;
            inst_pc_q    <= 32'd0;
            cache_wr_q   <= 1'b0;
            cache_data_q <= 32'd0;
            fetch_err_q  <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_idx_q    <= req_idx_d;
            rsp_idx_q    <= rsp_idx_d;
            asm_q        <= asm_d;
            cap_q        <= cap_d;
            stall_q      <= stall_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            cache_wr_q   <= cache_wr_d;
            cache_data_q <= cache_data_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

`ifdef ICACHE_FETCH_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Count accepted hits and misses; flushed requests never reach accept
    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(accept && cache_hit);
        miss_cnt_d = miss_cnt_q + 32'(accept && !cache_hit);
    end

    // Statistics registers, frozen with the rest of the block when rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: table vectors, directed corner sequences and randomized fetches for icache_fetch_ctrl.
module tb_icache_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, fetch_valid, flush, cache_hit, mem_gnt;
    logic [31:0] fetch_pc, cache_result;
    logic [7:0]  mem_din = 8'd0;
    logic        fetch_ready, inst_valid, fetch_err, cache_wr, mem_req;
    logic [31:0] inst_out, inst_pc, cache_addr, cache_data, mem_addr;
`ifdef ICACHE_FETCH_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    logic [7:0]  mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    icache_fetch_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
        .fetch_ready(fetch_ready), .inst_valid(inst_valid), .inst_out(inst_out),
        .inst_pc(inst_pc), .fetch_err(fetch_err),
        .cache_addr(cache_addr), .cache_wr(cache_wr), .cache_data(cache_data),
        .cache_hit(cache_hit), .cache_result(cache_result),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
`ifdef ICACHE_FETCH_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    // Arbiter/memory: an accepted grant returns its byte on the following cycle and holds it
    always @(posedge clk) if (rdy && mem_req && mem_gnt) mem_din <= mem[mem_addr[7:0]];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference word for a refill: four bytes from pc upward, lowest address in the low byte
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    task automatic run_hit(input logic [31:0] pc, input logic [31:0] res);
        fetch_valid = 1; fetch_pc = pc; cache_hit = 1; cache_result = res;
        flush = 0; rdy = 1; mem_gnt = 0;
        #1 chk("hit_cache_addr", cache_addr, pc);
        @(negedge clk);
        chk("hit_valid", inst_valid, 1);
        chk("hit_out", inst_out, res);
        chk("hit_pc", inst_pc, pc);
        chk("hit_no_req", mem_req, 0);
        chk("hit_no_wr", cache_wr, 0);
        fetch_valid = 0; cache_hit = 0;
        @(negedge clk);
        chk("hit_pulse", inst_valid, 0);
    endtask

    // gaps[k]: stall cycles before grant k; rdy_n cycles of rdy=0 are inserted before grant rdy_k
    task automatic run_miss(input logic [31:0] pc, input int gaps[4], input int rdy_k,
                            input int rdy_n, input logic exp_err);
        int cyc, exp_cyc, t;
        logic [31:0] w;
        w = word_at(pc);
        exp_cyc = 6 + gaps[0] + gaps[1] + gaps[2] + gaps[3] + rdy_n;
        fetch_valid = 1; fetch_pc = pc; cache_hit = 0; cache_result = 32'd0;
        flush = 0; mem_gnt = 0; rdy = 1;
        #1;
        chk("miss_ready", fetch_ready, 1);
        chk("miss_cache_addr", cache_addr, pc);
        @(negedge clk);
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                chk("stall_req", mem_req, 1);
                chk("stall_addr", mem_addr, pc + k);
                mem_gnt = 0;
                @(negedge clk); cyc++;
            end
            if (k == rdy_k) begin
                for (int r = 0; r < rdy_n; r++) begin
                    rdy = 0; mem_gnt = 1'($urandom);
                    @(negedge clk); cyc++;
                    chk("frozen_addr", mem_addr, pc + k);
                end
            end
            rdy = 1;
            chk("grant_req", mem_req, 1);
            chk("grant_addr", mem_addr, pc + k);
            chk("fill_cache_addr", cache_addr, pc);
            mem_gnt = 1;
            @(negedge clk); cyc++;
        end
        mem_gnt = 0;
        t = 0;
        while (inst_valid !== 1'b1 && t < 30) begin
            chk("no_early_wr", cache_wr, 0);
            @(negedge clk); cyc++; t++;
        end
        chk("miss_latency", cyc, exp_cyc);
        chk("miss_valid", inst_valid, 1);
        chk("miss_out", inst_out, w);
        chk("miss_pc", inst_pc, pc);
        chk("miss_wr", cache_wr, 1);
        chk("miss_wdata", cache_data, w);
        chk("miss_waddr", cache_addr, pc);
        chk("miss_busy", fetch_ready, 0);
        chk("miss_err", fetch_err, exp_err);
        fetch_valid = 0;
        @(negedge clk);
        chk("miss_pulse_valid", inst_valid, 0);
        chk("miss_pulse_wr", cache_wr, 0);
        chk("miss_idle", fetch_ready, 1);
        chk("miss_req_low", mem_req, 0);
    endtask

    typedef struct {
        logic        fv;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] res;
        logic        ev;
        logic [31:0] eout;
        logic [31:0] epc;
    } vec_t;

    vec_t        tv [6];
    int          g [4];
    logic [31:0] rpc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h13; mem[8'h11] = 8'h05; mem[8'h12] = 8'h10; mem[8'h13] = 8'h00;
        tv[0] = '{1'b1, 1'b0, 32'h10,       32'h00100513, 1'b1, 32'h00100513, 32'h10};
        tv[1] = '{1'b1, 1'b1, 32'h14,       32'hdeadbeef, 1'b0, 32'h0,        32'h0};
        tv[2] = '{1'b0, 1'b0, 32'h18,       32'h11111111, 1'b0, 32'h0,        32'h0};
        tv[3] = '{1'b1, 1'b0, 32'h1c,       32'hcafef00d, 1'b1, 32'hcafef00d, 32'h1c};
        tv[4] = '{1'b1, 1'b0, 32'hfffffffc, 32'h00000000, 1'b1, 32'h00000000, 32'hfffffffc};
        tv[5] = '{1'b1, 1'b0, 32'h00000000, 32'hffffffff, 1'b1, 32'hffffffff, 32'h0};

        rst = 1; rdy = 1; fetch_valid = 0; flush = 0; cache_hit = 0; mem_gnt = 0;
        fetch_pc = 0; cache_result = 0;
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_out", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_wr", cache_wr, 0);
        chk("rst_wdata", cache_data, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_ready", fetch_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fetch_valid = tv[i].fv; flush = tv[i].fl; cache_hit = 1;
            fetch_pc = tv[i].pc; cache_result = tv[i].res;
            #1 chk("tbl_cache_addr", cache_addr, tv[i].pc);
            @(negedge clk);
            chk("tbl_valid", inst_valid, tv[i].ev);
            if (tv[i].ev) begin
                chk("tbl_out", inst_out, tv[i].eout);
                chk("tbl_pc", inst_pc, tv[i].epc);
            end
            chk("tbl_no_req", mem_req, 0);
            chk("tbl_ready", fetch_ready, 1);
        end
        fetch_valid = 0; flush = 0; cache_hit = 0;
        @(negedge clk);

        g = '{0, 0, 0, 0}; run_miss(32'h10, g, 0, 0, 1'b0);
        run_hit(32'h10, 32'h00100513);
        g = '{0, 3, 0, 0}; run_miss(32'h10, g, 0, 0, 1'b0);
        g = '{0, 0, 0, 0}; run_miss(32'h24, g, 1, 5, 1'b0);
        g = '{1, 0, 2, 1}; run_miss(32'h80, g, 2, 5, 1'b0);

        // flush after two grants, with a third grant landing in the flush cycle
        fetch_valid = 1; fetch_pc = 32'h40; cache_hit = 0; rdy = 1; flush = 0; mem_gnt = 0;
        @(negedge clk);
        mem_gnt = 1;
        @(negedge clk); @(negedge clk);
        flush = 1; fetch_valid = 0;
        @(negedge clk);
        flush = 0; mem_gnt = 0;
        chk("flush_ready", fetch_ready, 1);
        chk("flush_req", mem_req, 0);
        chk("flush_valid", inst_valid, 0);
        chk("flush_wr", cache_wr, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_quiet_valid", inst_valid, 0);
            chk("flush_quiet_wr", cache_wr, 0);
        end
        g = '{0, 0, 0, 0}; run_miss(32'h20, g, 0, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            rpc = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 2) == 0) run_hit(rpc, $urandom());
            else begin
                for (int k = 0; k < 4; k++) g[k] = $urandom_range(0, 3);
                run_miss(rpc, g, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
            end
        end

        // asynchronous reset between clock edges in the middle of a refill
        fetch_valid = 1; fetch_pc = 32'h30; cache_hit = 0; mem_gnt = 0;
        @(negedge clk);
        mem_gnt = 1;
        @(negedge clk); @(negedge clk);
        mem_gnt = 0; fetch_valid = 0;
        #2 rst = 1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_ready", fetch_ready, 1);
        chk("arst_out", inst_out, 0);
        chk("arst_pc", inst_pc, 0);
        chk("arst_wdata", cache_data, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("arst_post_ready", fetch_ready, 1);
        chk("arst_post_wr", cache_wr, 0);
        chk("arst_post_valid", inst_valid, 0);

        g = '{255, 0, 0, 0}; run_miss(32'h50, g, 0, 0, 1'b0);
        g = '{0, 256, 0, 0}; run_miss(32'h54, g, 0, 0, 1'b1);
        chk("err_sticky", fetch_err, 1);
        rst = 1;
        #1 chk("err_cleared", fetch_err, 0);
        @(negedge clk);
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
